ray_column_buffer: RTL
======================

Name: ray_column_buffer

Overview:
- Sits directly downstream of the DDA stage.
- Consumes its AXI-Stream column records: 38 bits, {hcount_ray[8:0], lineHeight[7:0], wallType, mapData[3:0], wallX[15:0]}, with tlast on the final ray.
- Stores them in a double-buffered per-column memory.
- Answers per-pixel queries from the video timing path, returning region (ceiling/wall/floor), the wall row offset and the column's wall attributes, so the texture/colour stage can shade each pixel.

Parameters:
- SCREEN_WIDTH, 320, number of columns (rays) per frame.
- SCREEN_HEIGHT, 180, visible rows; horizon at SCREEN_HEIGHT/2.

Ports:
- pixel_clk_in  in  1  sole clock
- rst_in  in  1  asynchronous, active-high reset
- col_in_tvalid  in  1  DDA record valid
- col_in_tdata  in  38  DDA record
- col_in_tlast  in  1  last ray of frame
- col_in_tready  out  1  buffer can accept a record
- frame_start_in  in  1  one-cycle pulse at start of vertical blank; buffer swap point
- pixel_valid_in  in  1  pixel query valid
- hcount_in  in  9  query column
- vcount_in  in  8  query row
- pixel_valid_out  out  1  result valid
- hcount_out  out  9  delayed hcount_in
- vcount_out  out  8  delayed vcount_in
- region_out  out  2  0 CEIL, 1 WALL, 2 FLOOR, 3 NONE
- wall_row_out  out  8  vcount minus wall top; only meaningful when region_out is WALL
- lineHeight_out  out  8  column lineHeight
- wallType_out  out  1  column wallType
- mapData_out  out  4  column mapData
- wallX_out  out  16  column wallX
- front_valid_out  out  1  a complete frame has been displayed at least once
- drop_err_out  out  1  sticky flag: a record with hcount_ray >= SCREEN_WIDTH was received

Behaviour:
- Storage and bank select
  - Storage is 2*SCREEN_WIDTH entries of 29 bits {lineHeight, wallType, mapData, wallX}, addressed {bank, column}.
  - front_sel picks the bank being read; the write bank is !front_sel.
- Reset (asynchronous)
  - front_sel=0, back_full=0, front_valid_out=0, drop_err_out=0.
  - Pipeline valids cleared, so pixel_valid_out=0.
  - col_in_tready=1 after reset release; all other outputs 0.
  - Memory contents are not cleared.
  - Reset mid-frame discards the partial back frame.
- Write side
  - col_in_tready = !back_full.
  - Handshake occurs on tvalid && tready.
  - If hcount_ray < SCREEN_WIDTH, write entry at {!front_sel, hcount_ray}. Otherwise accept but drop, and set drop_err_out.
  - tlast on a handshake sets back_full on the next cycle. This applies even if that record was dropped.
  - Columns not written this frame keep their stale contents; no completeness check.
  - While back_full=1, no handshakes occur and tdata is ignored.
- Swap
  - On frame_start_in with registered back_full=1: toggle front_sel, clear back_full, set front_valid_out.
  - frame_start_in with back_full=0: no swap; the front bank is redisplayed.
  - tlast and frame_start_in in the same cycle: back_full is not yet 1, so no swap this cycle. The swap happens at the next frame_start_in.
- Read pipeline, fixed latency 2, no backpressure
  - Cycle 1: register the query; issue a synchronous memory read at {front_sel, hcount_in}. front_sel is sampled here, so a swap never splits a pixel.
  - Cycle 2: compute and register all outputs; pixel_valid_out equals pixel_valid_in delayed 2 cycles.
- Region arithmetic (signed, 10 bits)
  - top = SCREEN_HEIGHT/2 - (lineHeight>>1).
  - bot = top + lineHeight.
  - vcount < top gives CEIL; top <= vcount < bot gives WALL; otherwise FLOOR.
  - wall_row_out = (vcount - top) truncated to 8 bits; it is never negative when the region is WALL.
  - lineHeight = 0 means there is no wall.
  - Clamping is implicit: a wall that extends past the screen still yields correct wall_row values.
- NONE region
  - Returned when hcount_in >= SCREEN_WIDTH or front_valid_out = 0.
  - In that case attribute outputs are 0.

Decomposition:
- Package raycast_pkg holds:
  - region_t enum (CEIL, WALL, FLOOR, NONE).
  - col_entry_t packed struct (29 bits).
  - Field-slice localparams for the 38-bit DDA record; shared with the dda module.
- One sub-module, ray_column_bram: simple dual-port RAM (one write port, one read port, 1-cycle registered read), depth 2*SCREEN_WIDTH, width 29.

Test Plan:
1. Reset, then query (10,50) -> region NONE, front_valid_out=0, col_in_tready=1.
2. Stream 320 records all with lineHeight=60, tlast on the 320th, then pulse frame_start -> tready=0 after tlast until swap. Then query (5,59) -> CEIL, (5,60) -> WALL with row 0, (5,119) -> WALL with row 59, (5,120) -> FLOOR, each exactly 2 cycles after its query.
3. Column 7 with lineHeight=255; query (7,0) -> WALL with row 37. Column 8 with lineHeight=0; query (8,90) -> FLOOR.
4. Send a record with hcount_ray=400 -> accepted, drop_err_out=1, no entry written; subsequent records unaffected.
5. Assert tlast and frame_start in the same cycle -> no swap, old data still displayed. Next frame_start swaps -> new values read.
6. Assert rst_in mid-stream at column 100, release -> back_full=0, front_valid_out=0, NONE returned; a full new frame followed by frame_start restores normal output.

Source files
------------

// File: rtl/raycast_pkg.sv
// Types and field layout shared by the DDA stage and the column buffer.
package raycast_pkg;

   // Pixel classification handed to the shading stage
   typedef enum logic [1:0] {
      CEIL  = 2'd0,
      WALL  = 2'd1,
      FLOOR = 2'd2,
      NONE  = 2'd3
   } region_t;

   // Per-column wall attributes as stored in the column memory
   typedef struct packed {
      logic [7:0]  line_height;
      logic        wall_type;
      logic [3:0]  map_data;
      logic [15:0] wall_x;
   } col_entry_t;

   localparam int ENTRY_W = $bits(col_entry_t);

   // DDA record: {hcount_ray[8:0], lineHeight[7:0], wallType, mapData[3:0], wallX[15:0]}
   localparam int REC_W          = 38;
   localparam int REC_HCOUNT_MSB = 37;
   localparam int REC_HCOUNT_LSB = 29;
   localparam int REC_ENTRY_MSB  = 28;
   localparam int REC_ENTRY_LSB  = 0;

endpackage

// File: rtl/ray_column_bram.sv
// Simple dual-port column memory: one write port, one read port with a registered read.
module ray_column_bram #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 29,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Memory array write and one-cycle registered read; no reset so it maps onto block RAM
   always_ff @(posedge clk_i) begin
      if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ray_column_buffer.sv
// Double-buffered per-column store between the DDA stage and the pixel shader.
// The DDA fills the back bank; the video path reads the front bank with a fixed
// two-cycle latency and gets region / wall row / wall attributes per pixel.
module ray_column_buffer
   import raycast_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 180
) (
   input  logic             pixel_clk_in,
   input  logic             rst_in,
   input  logic             col_in_tvalid,
   input  logic [REC_W-1:0] col_in_tdata,
   input  logic             col_in_tlast,
   output logic             col_in_tready,
   input  logic             frame_start_in,
   input  logic             pixel_valid_in,
   input  logic [8:0]       hcount_in,
   input  logic [7:0]       vcount_in,
   output logic             pixel_valid_out,
   output logic [8:0]       hcount_out,
   output logic [7:0]       vcount_out,
   output logic [1:0]       region_out,
   output logic [7:0]       wall_row_out,
   output logic [7:0]       lineHeight_out,
   output logic             wallType_out,
   output logic [3:0]       mapData_out,
   output logic [15:0]      wallX_out,
   output logic             front_valid_out,
   output logic             drop_err_out
);

   localparam int                DEPTH       = 2 * SCREEN_WIDTH;
   localparam int                AW          = $clog2(DEPTH);
   localparam logic [AW-1:0]     BANK1_BASE  = AW'(SCREEN_WIDTH);
   localparam logic [8:0]        WIDTH_LIMIT = 9'(SCREEN_WIDTH);
   localparam logic signed [9:0] HORIZON     = 10'(SCREEN_HEIGHT / 2);

   // Bank 0 occupies [0, W), bank 1 occupies [W, 2W)
   function automatic logic [AW-1:0] bank_addr(input logic bank, input logic [8:0] col);
      return (bank ? BANK1_BASE : '0) + AW'(col);
   endfunction

   // ---------------- bank control state ----------------
   logic front_sel_q,   front_sel_d;
   logic back_full_q,   back_full_d;
   logic front_valid_q, front_valid_d;
   logic drop_err_q,    drop_err_d;

   logic [8:0]  rec_hcount;
   col_entry_t  rec_entry;
   logic        handshake;
   logic        rec_in_range;
   logic        swap;

   assign rec_hcount   = col_in_tdata[REC_HCOUNT_MSB:REC_HCOUNT_LSB];
   assign rec_entry    = col_entry_t'(col_in_tdata[REC_ENTRY_MSB:REC_ENTRY_LSB]);
   assign handshake    = col_in_tvalid && !back_full_q;
   assign rec_in_range = rec_hcount < WIDTH_LIMIT;
   assign swap         = frame_start_in && back_full_q;

   // Bank bookkeeping: swap on frame start once the back frame is complete, stall the DDA otherwise
   always_comb begin
      front_sel_d   = front_sel_q;
      back_full_d   = back_full_q;
      front_valid_d = front_valid_q;
      drop_err_d    = drop_err_q;
      if (swap) begin
         front_sel_d   = !front_sel_q;
         back_full_d   = 1'b0;
         front_valid_d = 1'b1;
      end else if (handshake && col_in_tlast) begin
         // tlast closes the frame even when that record itself was dropped
         back_full_d = 1'b1;
      end
      if (handshake && !rec_in_range) begin
         drop_err_d = 1'b1;
      end
   end

   // Bank control registers
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         front_sel_q   <= 1'b0;
         back_full_q   <= 1'b0;
         front_valid_q <= 1'b0;
         drop_err_q    <= 1'b0;
      end else begin
         front_sel_q   <= front_sel_d;
         back_full_q   <= back_full_d;
         front_valid_q <= front_valid_d;
         drop_err_q    <= drop_err_d;
      end
   end

   // ---------------- column memory ----------------
   logic               query_in_range;
   logic [AW-1:0]      rd_addr;
   logic [ENTRY_W-1:0] rd_data;

   assign query_in_range = hcount_in < WIDTH_LIMIT;
   // Out-of-range queries read a harmless in-range address; their result is forced to NONE
   assign rd_addr = bank_addr(front_sel_q, query_in_range ? hcount_in : 9'd0);

   ray_column_bram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_bram (
      .clk_i     (pixel_clk_in),
      .wr_en_i   (handshake && rec_in_range),
      .wr_addr_i (bank_addr(!front_sel_q, rec_hcount)),
      .wr_data_i (rec_entry),
      .rd_en_i   (pixel_valid_in),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   // ---------------- read pipeline stage 1 ----------------
   logic       s1_valid_q,  s1_valid_d;
   logic [8:0] s1_hcount_q, s1_hcount_d;
   logic [7:0] s1_vcount_q, s1_vcount_d;
   logic       s1_none_q,   s1_none_d;

   // Capture the query alongside the memory read; front state is sampled here so a swap never splits a pixel
   always_comb begin
      s1_valid_d  = pixel_valid_in;
      s1_hcount_d = hcount_in;
      s1_vcount_d = vcount_in;
      s1_none_d   = !query_in_range || !front_valid_q;
   end

   // Stage 1 registers
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid_q  <= 1'b0;
         s1_hcount_q <= '0;
         s1_vcount_q <= '0;
         s1_none_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_hcount_q <= s1_hcount_d;
         s1_vcount_q <= s1_vcount_d;
         s1_none_q   <= s1_none_d;
      end
   end

   // ---------------- read pipeline stage 2 ----------------
   col_entry_t         rd_entry;
   logic signed [9:0]  top_s;
   logic signed [9:0]  bot_s;
   logic signed [9:0]  vpos_s;
   logic signed [9:0]  row_s;

   logic        out_valid_q,  out_valid_d;
   logic [8:0]  out_hcount_q, out_hcount_d;
   logic [7:0]  out_vcount_q, out_vcount_d;
   region_t     region_q,     region_d;
   logic [7:0]  wall_row_q,   wall_row_d;
   col_entry_t  attr_q,       attr_d;

   assign rd_entry = col_entry_t'(rd_data);
   // Wall spans [top, bot) around the horizon; negative top / oversized bot handle walls taller than the screen
   assign top_s  = HORIZON - $signed({3'b000, rd_entry.line_height[7:1]});
   assign bot_s  = top_s + $signed({2'b00, rd_entry.line_height});
   assign vpos_s = $signed({2'b00, s1_vcount_q});
   assign row_s  = vpos_s - top_s;

   // Classify the pixel and select attributes; result registers hold their value between queries
   always_comb begin
      out_valid_d  = s1_valid_q;
      out_hcount_d = out_hcount_q;
      out_vcount_d = out_vcount_q;
      region_d     = region_q;
      wall_row_d   = wall_row_q;
      attr_d       = attr_q;
      if (s1_valid_q) begin
         out_hcount_d = s1_hcount_q;
         out_vcount_d = s1_vcount_q;
         if (s1_none_q) begin
            region_d   = NONE;
            wall_row_d = '0;
            attr_d     = '0;
         end else begin
            attr_d     = rd_entry;
            wall_row_d = row_s[7:0];
            if (vpos_s < top_s) begin
               region_d = CEIL;
            end else if (vpos_s < bot_s) begin
               region_d = WALL;
            end else begin
               region_d = FLOOR;
            end
         end
      end
   end

   // Stage 2 (output) registers
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         out_valid_q  <= 1'b0;
         out_hcount_q <= '0;
         out_vcount_q <= '0;
         region_q     <= CEIL;
         wall_row_q   <= '0;
         attr_q       <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_hcount_q <= out_hcount_d;
         out_vcount_q <= out_vcount_d;
         region_q     <= region_d;
         wall_row_q   <= wall_row_d;
         attr_q       <= attr_d;
      end
   end

   assign col_in_tready   = !back_full_q;
   assign front_valid_out = front_valid_q;
   assign drop_err_out    = drop_err_q;
   assign pixel_valid_out = out_valid_q;
   assign hcount_out      = out_hcount_q;
   assign vcount_out      = out_vcount_q;
   assign region_out      = region_q;
   assign wall_row_out    = wall_row_q;
   assign lineHeight_out  = attr_q.line_height;
   assign wallType_out    = attr_q.wall_type;
   assign mapData_out     = attr_q.map_data;
   assign wallX_out       = attr_q.wall_x;

endmodule
